regfile_dual_write: RTL and testbench
=====================================

REGFILE_DUAL_WRITE -- requirements
Module: regfile_dual_write

Interface
REQ-001 The block SHALL expose these ports:
- clk  input  1  single clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-low; 0 clears all state immediately.
- wrData  input  16  write-port-1 data (ALU result bus).
- regWrite  input  4  write-port-1 address.
- regWriteEn  input  1  write-port-1 enable.
- wrData2  input  16  write-port-2 data.
- regWrite2  input  4  write-port-2 address.
- regWriteEn2  input  1  write-port-2 enable.
- regRead1  input  4  read-port-1 address.
- regRead2  input  4  read-port-2 address.
- readData1  output  16  read-port-1 data.
- readData2  output  16  read-port-2 data.
- dumpStart  input  1  pulse; requests a sequential dump of R0..R15.
- dumpData  output  16  dumped register value.
- dumpAddr  output  4  index of dumped register.
- dumpValid  output  1  dumpData/dumpAddr valid this cycle.
- dumpBusy  output  1  dump sequence in progress.

REQ-002 The clock SHALL be one clock; reset SHALL be asynchronous and active-low.

Function
REQ-003 The block SHALL hold sixteen 16-bit registers R0..R15; R0 is ordinary storage, not hardwired.
REQ-004 On a rising edge with regWriteEn=1, R[regWrite] SHALL take wrData.
REQ-005 On a rising edge with regWriteEn2=1, R[regWrite2] SHALL take wrData2.
REQ-006 If both enables are 1 and the addresses are equal, port 1 SHALL win, and the port-2 data SHALL be discarded.
REQ-007 If both enables are 1 and the addresses differ, both writes SHALL complete on the same edge.
REQ-008 readData1/readData2 SHALL be combinational from the stored array, with zero-cycle latency.
REQ-009 The dump FSM SHALL have states IDLE and SCAN, plus a 4-bit pointer ptr.
REQ-010 In IDLE, an edge with dumpStart=1 SHALL move the FSM to SCAN with ptr=0; dumpStart=0 SHALL keep it in IDLE.
REQ-011 On each edge in SCAN:
- dumpData<=R[ptr] (value before any same-edge write), dumpAddr<=ptr, dumpValid<=1.
- ptr increments.
- If ptr was 15, the FSM returns to IDLE.
REQ-012 dumpValid SHALL be high for exactly 16 consecutive cycles per dump, with dumpAddr 0..15 in order; otherwise dumpValid=0.
REQ-013 The dump outputs SHALL hold their last values after the dump, with dumpValid low.
REQ-014 dumpBusy SHALL be 1 exactly while the FSM is in SCAN.
REQ-015 dumpStart SHALL be ignored while in SCAN; there is no queueing and no restart.
REQ-016 Register writes SHALL proceed normally during a dump, and the dump SHALL never stall writes.

Reset
REQ-017 While reset=0, R0..R15 SHALL be 0, the FSM SHALL be IDLE, ptr=0, dumpData=0, dumpAddr=0, dumpValid=0 and dumpBusy=0.
REQ-018 Reset asserted mid-dump SHALL abort the dump immediately, with no further dumpValid until a new dumpStart.
REQ-019 On the first edge after reset release, writes and dumpStart SHALL be honoured.

Configuration
REQ-020 With REGFILE_BYPASS_EN defined, a read port addressing a register being written this cycle SHALL return the write data combinationally.
- Port-1 data takes precedence if both write ports target that address.
REQ-021 Without REGFILE_BYPASS_EN, reads SHALL return the stored value only, and the new value SHALL be visible the cycle after the write.
REQ-022 The dump path SHALL be unaffected by REGFILE_BYPASS_EN.

Verification
REQ-023 Write: reset, then write R3=16'h0007 on port 1; next cycle regRead1=3 -> readData1=16'h0007, and all other registers read 0.
REQ-024 Dual write: port1 R5=16'h000D and port2 R12=16'h0014 on the same edge -> R5=16'h000D, R12=16'h0014.
REQ-025 Collision: both ports write R9, port1 16'hAAAA and port2 16'h5555 -> R9=16'hAAAA.
REQ-026 Same-cycle read: write R2=16'h1234 while regRead2=2.
- With REGFILE_BYPASS_EN: readData2=16'h1234 in that cycle.
- Without: readData2=old value, then 16'h1234 the next cycle.
REQ-027 Dump: load Rn=n+1, pulse dumpStart -> 16 cycles of dumpValid with (dumpAddr, dumpData)=(0,1)..(15,16) and dumpBusy high throughout.
- A second dumpStart at the 5th valid cycle is ignored.
REQ-028 Reset mid-dump: drive reset=0 at dumpAddr=7 -> dumpValid, dumpBusy and all registers read 0 immediately.
- No further dumpValid after release until a new dumpStart.

Source files
------------

// File: rtl/regfile_dual_write.sv
// Sixteen-entry 16-bit register file with two write ports, two combinational read ports
// and a sequential dump engine. Define REGFILE_BYPASS_EN for write-to-read forwarding.
module regfile_dual_write (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] wrData,
  input  logic [3:0]  regWrite,
  input  logic        regWriteEn,
  input  logic [15:0] wrData2,
  input  logic [3:0]  regWrite2,
  input  logic        regWriteEn2,
  input  logic [3:0]  regRead1,
  input  logic [3:0]  regRead2,
  output logic [15:0] readData1,
  output logic [15:0] readData2,
  input  logic        dumpStart,
  output logic [15:0] dumpData,
  output logic [3:0]  dumpAddr,
  output logic        dumpValid,
  output logic        dumpBusy
);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t      state, state_next;
  logic [3:0]  ptr, ptr_next;
  logic [15:0] regs [16];

  // NOTE: the array is cleared by reset because every register must read 0 while reset
  // is low; that rules out a RAM macro but is what the block promises.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 16; i++) regs[i] <= '0;
    end else begin
      // Port 1 is written last so it overrides port 2 on an address collision.
      if (regWriteEn2) regs[regWrite2] <= wrData2;
      if (regWriteEn)  regs[regWrite]  <= wrData;
    end
  end

`ifdef REGFILE_BYPASS_EN
  always_comb begin
    readData1 = regs[regRead1];
    if (regWriteEn2 && regWrite2 == regRead1) readData1 = wrData2;
    if (regWriteEn  && regWrite  == regRead1) readData1 = wrData;
  end

  always_comb begin
    readData2 = regs[regRead2];
    if (regWriteEn2 && regWrite2 == regRead2) readData2 = wrData2;
    if (regWriteEn  && regWrite  == regRead2) readData2 = wrData;
  end
`else
  assign readData1 = regs[regRead1];
  assign readData2 = regs[regRead2];
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      ptr   <= '0;
    end else begin
      state <= state_next;
      ptr   <= ptr_next;
    end
  end

  // NOTE: defaults first so every path assigns both signals and no latch is inferred.
  always_comb begin
    state_next = state;
    ptr_next   = ptr;
    case (state)
      IDLE: begin
        if (dumpStart) begin
          state_next = SCAN;
          ptr_next   = '0;
        end
      end
      SCAN: begin
        ptr_next = ptr + 4'd1;
        if (ptr == 4'd15) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Dump samples the pre-edge array value; same-edge writes land one cycle later.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dumpData  <= '0;
      dumpAddr  <= '0;
      dumpValid <= 1'b0;
    end else if (state == SCAN) begin
      dumpData  <= regs[ptr];
      dumpAddr  <= ptr;
      dumpValid <= 1'b1;
    end else begin
      dumpValid <= 1'b0;
    end
  end

  assign dumpBusy = (state == SCAN);

endmodule

// File: tb/tb_regfile_dual_write.sv
// Self-checking bench for regfile_dual_write: directed scenarios plus random traffic
// compared against an array-based reference model.
module tb_regfile_dual_write;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] wrData, wrData2;
  logic [3:0]  regWrite, regWrite2, regRead1, regRead2;
  logic        regWriteEn, regWriteEn2, dumpStart;
  logic [15:0] readData1, readData2, dumpData;
  logic [3:0]  dumpAddr;
  logic        dumpValid, dumpBusy;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  logic [15:0] mr [16];
  bit          m_scan;
  int          m_idx;
  logic [15:0] e_data;
  logic [3:0]  e_addr;
  logic        e_valid;

  regfile_dual_write dut (
    .clk(clk), .reset(reset),
    .wrData(wrData), .regWrite(regWrite), .regWriteEn(regWriteEn),
    .wrData2(wrData2), .regWrite2(regWrite2), .regWriteEn2(regWriteEn2),
    .regRead1(regRead1), .regRead2(regRead2),
    .readData1(readData1), .readData2(readData2),
    .dumpStart(dumpStart), .dumpData(dumpData), .dumpAddr(dumpAddr),
    .dumpValid(dumpValid), .dumpBusy(dumpBusy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] exp_read(input logic [3:0] a);
`ifdef REGFILE_BYPASS_EN
    if (regWriteEn && regWrite == a) return wrData;
    if (regWriteEn2 && regWrite2 == a) return wrData2;
`endif
    return mr[a];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) mr[i] = '0;
    m_scan = 0; m_idx = 0;
    e_data = '0; e_addr = '0; e_valid = 1'b0;
  endtask

  task automatic model_edge();
    if (!reset) begin
      model_reset();
      return;
    end
    if (m_scan) begin
      e_data  = mr[m_idx];
      e_addr  = 4'(m_idx);
      e_valid = 1'b1;
      m_idx++;
      if (m_idx == 16) m_scan = 0;
    end else begin
      e_valid = 1'b0;
      if (dumpStart) begin
        m_scan = 1;
        m_idx  = 0;
      end
    end
    if (regWriteEn2) mr[regWrite2] = wrData2;
    if (regWriteEn)  mr[regWrite]  = wrData;
  endtask

  task automatic check_outputs();
    check("read1", readData1, exp_read(regRead1));
    check("read2", readData2, exp_read(regRead2));
    check("dump_valid", 16'(dumpValid), 16'(e_valid));
    check("dump_busy", 16'(dumpBusy), 16'(m_scan));
    check("dump_data", dumpData, e_data);
    check("dump_addr", 16'(dumpAddr), 16'(e_addr));
  endtask

  // Inputs are set just after a falling edge; compare, take the rising edge, return at next fall.
  task automatic cycle();
    #1;
    check_outputs();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    regWriteEn = 0; regWriteEn2 = 0; dumpStart = 0;
    wrData = '0; wrData2 = '0; regWrite = '0; regWrite2 = '0;
  endtask

  int seen;
  bit found;

  initial begin
    reset = 0;
    idle_inputs();
    regRead1 = '0; regRead2 = '0;
    model_reset();
    #1;
    check_outputs();
    @(negedge clk);
    reset = 1;

    // Single write, then sweep every register
    regWriteEn = 1; regWrite = 4'd3; wrData = 16'h0007; regRead1 = 4'd3;
    cycle();
    idle_inputs();
    for (int i = 0; i < 16; i++) begin
      regRead1 = 4'(i); regRead2 = 4'(15 - i);
      #1;
      check("sweep1", readData1, (i == 3) ? 16'h0007 : 16'h0000);
      check("sweep2", readData2, (i == 12) ? 16'h0007 : 16'h0000);
      cycle();
    end

    // Dual write to distinct addresses
    regWriteEn = 1; regWrite = 4'd5; wrData = 16'h000D;
    regWriteEn2 = 1; regWrite2 = 4'd12; wrData2 = 16'h0014;
    cycle();
    idle_inputs();
    regRead1 = 4'd5; regRead2 = 4'd12;
    #1;
    check("dual_r5", readData1, 16'h000D);
    check("dual_r12", readData2, 16'h0014);
    cycle();

    // Collision: port 1 wins
    regWriteEn = 1; regWrite = 4'd9; wrData = 16'hAAAA;
    regWriteEn2 = 1; regWrite2 = 4'd9; wrData2 = 16'h5555;
    cycle();
    idle_inputs();
    regRead1 = 4'd9;
    #1;
    check("collision_r9", readData1, 16'hAAAA);
    cycle();

    // Same-cycle read of the register being written
    regWriteEn = 1; regWrite = 4'd2; wrData = 16'h1234; regRead2 = 4'd2;
    #1;
`ifdef REGFILE_BYPASS_EN
    check("same_cycle_r2", readData2, 16'h1234);
`else
    check("same_cycle_r2", readData2, 16'h0000);
`endif
    cycle();
    idle_inputs();
    #1;
    check("next_cycle_r2", readData2, 16'h1234);
    cycle();

    // Load Rn = n+1 two registers per cycle
    for (int i = 0; i < 8; i++) begin
      regWriteEn = 1; regWrite = 4'(2 * i); wrData = 16'(2 * i + 1);
      regWriteEn2 = 1; regWrite2 = 4'(2 * i + 1); wrData2 = 16'(2 * i + 2);
      cycle();
    end
    idle_inputs();

    // Full dump with an ignored restart request on the fifth valid cycle
    dumpStart = 1;
    cycle();
    dumpStart = 0;
    seen = 0;
    for (int c = 0; c < 40 && seen < 16; c++) begin
      dumpStart = 0;
      if (dumpValid) begin
        check("dump_seq_addr", 16'(dumpAddr), 16'(seen));
        check("dump_seq_data", dumpData, 16'(seen + 1));
        if (seen == 4) dumpStart = 1;
        seen++;
      end
      cycle();
    end
    dumpStart = 0;
    check("dump_count", 16'(seen), 16'd16);
    for (int c = 0; c < 4; c++) begin
      #1;
      check("post_dump_valid", 16'(dumpValid), 16'd0);
      check("post_dump_hold", 16'(dumpAddr), 16'd15);
      cycle();
    end

    // Reset in the middle of a dump
    dumpStart = 1;
    cycle();
    dumpStart = 0;
    found = 0;
    for (int c = 0; c < 30; c++) begin
      if (dumpValid && dumpAddr == 4'd7) begin
        found = 1;
        break;
      end
      cycle();
    end
    check("mid_dump_reached", 16'(found), 16'd1);
    reset = 0;
    #1;
    model_reset();
    check("rst_valid", 16'(dumpValid), 16'd0);
    check("rst_busy", 16'(dumpBusy), 16'd0);
    check("rst_data", dumpData, 16'h0000);
    for (int i = 0; i < 16; i++) begin
      regRead1 = 4'(i);
      #1;
      check("rst_regs", readData1, 16'h0000);
    end
    @(negedge clk);
    reset = 1;
    for (int c = 0; c < 20; c++) cycle();

    // Random traffic
    for (int c = 0; c < 400; c++) begin
      regWriteEn  = 1'($urandom_range(0, 1));
      regWriteEn2 = 1'($urandom_range(0, 1));
      regWrite    = 4'($urandom_range(0, 15));
      regWrite2   = ($urandom_range(0, 3) == 0) ? regWrite : 4'($urandom_range(0, 15));
      wrData      = 16'($urandom);
      wrData2     = 16'($urandom);
      regRead1    = ($urandom_range(0, 2) == 0) ? regWrite : 4'($urandom_range(0, 15));
      regRead2    = ($urandom_range(0, 2) == 0) ? regWrite2 : 4'($urandom_range(0, 15));
      dumpStart   = ($urandom_range(0, 19) == 0);
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
